// File: rtl/dtc_arb_pkg.sv
// ============================================================================
// Module   : dtc_arb_pkg
// Brief    : Shared types and constants for the shared-classifier arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

package dtc_arb_pkg;

  localparam int c_DEF_FEAT_W  = 12;
  localparam int c_DEF_CLASS_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EVAL = 2'd1,
    ST_RESP = 2'd2
  } arb_state_t;

  // Index width that stays legal (>=1) for a single-entry range.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dtc_rr_pick.sv
// ============================================================================
// Module   : dtc_rr_pick
// Brief    : Combinational rotate-priority picker (search from ptr upward, wrap).
// Revision : 1.0
// ============================================================================
`default_nettype none

module dtc_rr_pick
  import dtc_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    idx,
  output logic               any_valid
);

  logic [ID_W-1:0] w_pos;

  always_comb begin
    grant     = '0;
    idx       = '0;
    any_valid = 1'b0;
    w_pos     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_pos = ID_W'((int'(ptr) + k) % NUM_REQ);
      if (!any_valid && req[w_pos]) begin
        any_valid    = 1'b1;
        idx          = w_pos;
        grant[w_pos] = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/dtc_shared_arbiter.sv
// ============================================================================
// Module   : dtc_shared_arbiter
// Brief    : Round-robin sharing of one combinational classifier between
//            NUM_REQ requesters with a multicycle evaluation window.
// Revision : 1.0
// ============================================================================
`default_nettype none

module dtc_shared_arbiter
  import dtc_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int FEAT_W      = c_DEF_FEAT_W,
  parameter int CLASS_W     = c_DEF_CLASS_W,
  parameter int EVAL_CYCLES = 1,
  localparam int ID_W       = id_width(NUM_REQ)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ*FEAT_W-1:0]   req_feat,
  output logic [FEAT_W-1:0]           dt_inp,
  input  logic [CLASS_W-1:0]          dt_outp,
  output logic                        res_valid,
  input  logic                        res_ready,
  output logic [CLASS_W-1:0]          res_class,
  output logic [ID_W-1:0]             res_id,
  output logic                        busy
);

  localparam int            CNT_W      = id_width(EVAL_CYCLES);
  localparam logic [CNT_W-1:0] c_CNT_LOAD = CNT_W'(EVAL_CYCLES - 1);
  localparam logic [ID_W-1:0]  c_LAST_ID  = ID_W'(NUM_REQ - 1);

  arb_state_t           r_state;
  arb_state_t           w_state_nxt;
  logic [ID_W-1:0]      r_rr_ptr;
  logic [CNT_W-1:0]     r_cnt;
  logic [FEAT_W-1:0]    r_dt_inp;
  logic [CLASS_W-1:0]   r_res_class;
  logic [ID_W-1:0]      r_res_id;
  logic                 r_res_valid;

  logic [NUM_REQ-1:0]   w_grant;
  logic [ID_W-1:0]      w_idx;
  logic                 w_any;
  logic [FEAT_W-1:0]    w_feat [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_feat_unpack
    assign w_feat[i] = req_feat[i*FEAT_W +: FEAT_W];
  end

  dtc_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .req       (req_valid),
    .ptr       (r_rr_ptr),
    .grant     (w_grant),
    .idx       (w_idx),
    .any_valid (w_any)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Grant is only offered from IDLE; EVAL and RESP backpressure all requesters.
  always_comb begin
    w_state_nxt = r_state;
    req_ready   = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          req_ready   = w_grant;
          w_state_nxt = ST_EVAL;
        end
      end
      ST_EVAL: begin
        if (r_cnt == '0) w_state_nxt = ST_RESP;
      end
      ST_RESP: begin
        if (r_res_valid && res_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // dt_inp only moves on a grant edge, keeping the classifier input stable
  // across the whole EVAL window (multicycle path).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr    <= '0;
      r_cnt       <= '0;
      r_dt_inp    <= '0;
      r_res_class <= '0;
      r_res_id    <= '0;
      r_res_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_dt_inp <= w_feat[w_idx];
            r_res_id <= w_idx;
            r_rr_ptr <= (w_idx == c_LAST_ID) ? '0 : w_idx + 1'b1;
            r_cnt    <= c_CNT_LOAD;
          end
        end
        ST_EVAL: begin
          if (r_cnt == '0) begin
            r_res_class <= dt_outp;
            r_res_valid <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_RESP: begin
          if (res_ready) r_res_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign dt_inp    = r_dt_inp;
  assign res_valid = r_res_valid;
  assign res_class = r_res_class;
  assign res_id    = r_res_id;
  assign busy      = (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_dtc_shared_arbiter.sv
// ============================================================================
// Module   : tb_dtc_shared_arbiter
// Brief    : Scoreboard bench for dtc_shared_arbiter (EVAL_CYCLES=1 and 3).
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_dtc_shared_arbiter;

  localparam int N  = 4;
  localparam int FW = 12;
  localparam int CW = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Instance with EVAL_CYCLES=1
  logic [N-1:0]    req_valid, req_ready;
  logic [N*FW-1:0] req_feat;
  logic [FW-1:0]   dt_inp;
  logic [CW-1:0]   dt_outp, res_class;
  logic            res_valid, res_ready, busy;
  logic [1:0]      res_id;
  assign dt_outp = dt_inp[2:0];

  // Instance with EVAL_CYCLES=3
  logic [N-1:0]    b_req_valid, b_req_ready;
  logic [N*FW-1:0] b_req_feat;
  logic [FW-1:0]   b_dt_inp;
  logic [CW-1:0]   b_dt_outp, b_res_class;
  logic            b_res_valid, b_res_ready, b_busy;
  logic [1:0]      b_res_id;
  assign b_dt_outp = b_dt_inp[2:0];

  dtc_shared_arbiter #(.NUM_REQ(N), .FEAT_W(FW), .CLASS_W(CW), .EVAL_CYCLES(1)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_feat(req_feat), .dt_inp(dt_inp), .dt_outp(dt_outp),
    .res_valid(res_valid), .res_ready(res_ready), .res_class(res_class),
    .res_id(res_id), .busy(busy)
  );

  dtc_shared_arbiter #(.NUM_REQ(N), .FEAT_W(FW), .CLASS_W(CW), .EVAL_CYCLES(3)) u_dut3 (
    .clk(clk), .rst(rst), .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_feat(b_req_feat), .dt_inp(b_dt_inp), .dt_outp(b_dt_outp),
    .res_valid(b_res_valid), .res_ready(b_res_ready), .res_class(b_res_class),
    .res_id(b_res_id), .busy(b_busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [N-1:0] exp_grant_q [$];
  logic [4:0]   exp_res_q   [$];   // {id, class}

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops expected grants / results whenever the DUT presents them.
  always @(negedge clk) begin
    if (!rst) begin
      if (req_ready != '0) begin
        if (exp_grant_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_grant: got 0x%0h, expected none", req_ready);
        end else begin
          check("grant", 32'(req_ready), 32'(exp_grant_q.pop_front()));
        end
      end
      if (res_valid && res_ready) begin
        if (exp_res_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_result: got id=%0d class=%0d, expected none", res_id, res_class);
        end else begin
          check("result", 32'({res_id, res_class}), 32'(exp_res_q.pop_front()));
        end
      end
    end
  end

  task automatic set_req(input int i, input logic [FW-1:0] feat);
    req_feat[i*FW +: FW] = feat;
    req_valid[i]         = 1'b1;
  endtask

  task automatic drive_grants(input int n, input bit drop);
    int got = 0;
    int cyc = 0;
    logic [N-1:0] g;
    while (got < n && cyc < 100) begin
      @(negedge clk);
      g = req_ready;
      if (g != '0) got++;
      @(posedge clk); #1;
      if (drop) req_valid = req_valid & ~g;
      cyc++;
    end
    check("grant_count", 32'(got), 32'(n));
  endtask

  task automatic wait_drain();
    int cyc = 0;
    while ((exp_grant_q.size() != 0 || exp_res_q.size() != 0) && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("drain", 32'(exp_grant_q.size() + exp_res_q.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int cyc;
    req_valid   = '0; req_feat   = '0; res_ready   = 1'b1;
    b_req_valid = '0; b_req_feat = '0; b_res_ready = 1'b1;
    rst = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 0);
    check("rst_dt_inp",    32'(dt_inp),    0);
    check("rst_res_valid", 32'(res_valid), 0);
    check("rst_res_class", 32'(res_class), 0);
    check("rst_res_id",    32'(res_id),    0);
    check("rst_busy",      32'(busy),      0);
    check("rst_b_busy",    32'(b_busy),    0);
    check("rst_b_valid",   32'(b_res_valid), 0);
    @(posedge clk); #1 rst = 1'b0;

    // Single request, requester 2, latency EVAL_CYCLES+1
    set_req(2, 12'h005);
    exp_grant_q.push_back(4'b0100);
    exp_res_q.push_back({2'd2, 3'd5});
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (req_ready == '0 && cyc < 20);
    check("single_grant_seen", 32'(req_ready), 32'b0100);
    @(posedge clk); #1 req_valid = '0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!res_valid && lat < 20);
    check("latency_e1", 32'(lat), 2);
    check("single_class", 32'(res_class), 5);
    check("single_id",    32'(res_id),    2);
    wait_drain();

    // All four from reset: round-robin 0,1,2,3 with wrap
    rst = 1'b1; @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < N; i++) begin
      set_req(i, 12'(i + 1));
      exp_grant_q.push_back(4'(1 << i));
      exp_res_q.push_back({2'(i), 3'(i + 1)});
    end
    drive_grants(4, 1'b1);
    wait_drain();

    // Fairness: 0 and 3 held continuously
    set_req(0, 12'h00A);
    set_req(3, 12'h00E);
    for (int k = 0; k < 2; k++) begin
      exp_grant_q.push_back(4'b0001); exp_res_q.push_back({2'd0, 3'd2});
      exp_grant_q.push_back(4'b1000); exp_res_q.push_back({2'd3, 3'd6});
    end
    drive_grants(4, 1'b0);
    req_valid = '0;
    wait_drain();

    // Backpressure with a competing request pending
    res_ready = 1'b0;
    set_req(1, 12'h00B);
    exp_grant_q.push_back(4'b0010);
    exp_res_q.push_back({2'd1, 3'd3});
    drive_grants(1, 1'b1);
    set_req(2, 12'h006);
    exp_grant_q.push_back(4'b0100);
    exp_res_q.push_back({2'd2, 3'd6});
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!res_valid && cyc < 20);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      check("bp_valid", 32'(res_valid), 1);
      check("bp_class", 32'(res_class), 3);
      check("bp_id",    32'(res_id),    1);
      check("bp_ready", 32'(req_ready), 0);
    end
    @(posedge clk); #1 res_ready = 1'b1;
    @(negedge clk);
    check("bp_accept_no_grant", 32'(req_ready), 0);
    @(negedge clk);
    check("bp_next_grant", 32'(req_ready), 32'b0100);
    @(posedge clk); #1 req_valid = '0;
    wait_drain();

    // Reset while in EVAL: discard, restart with rr_ptr=0
    set_req(1, 12'h001);
    exp_grant_q.push_back(4'b0010);
    drive_grants(1, 1'b1);
    rst = 1'b1;
    #1;
    check("mid_rst_valid",  32'(res_valid), 0);
    check("mid_rst_busy",   32'(busy),      0);
    check("mid_rst_dt_inp", 32'(dt_inp),    0);
    @(posedge clk); #1 rst = 1'b0;
    set_req(0, 12'h003);
    set_req(1, 12'h002);
    exp_grant_q.push_back(4'b0001); exp_res_q.push_back({2'd0, 3'd3});
    exp_grant_q.push_back(4'b0010); exp_res_q.push_back({2'd1, 3'd2});
    drive_grants(2, 1'b1);
    wait_drain();

    // EVAL_CYCLES=3 instance
    b_req_feat[1*FW +: FW] = 12'h007;
    b_req_valid[1]         = 1'b1;
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (b_req_ready == '0 && cyc < 20);
    check("e3_grant", 32'(b_req_ready), 32'b0010);
    @(posedge clk); #1 b_req_valid = '0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check("e3_dt_inp", 32'(b_dt_inp),    32'h007);
      check("e3_busy",   32'(b_busy),      1);
      check("e3_valid",  32'(b_res_valid), (k == 4) ? 32'd1 : 32'd0);
    end
    check("e3_class", 32'(b_res_class), 7);
    check("e3_id",    32'(b_res_id),    1);
    @(negedge clk);
    check("e3_idle", 32'(b_busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
